// File: rtl/adc_controller.sv
// Sequencer for an 8-channel simultaneous-sampling ADC with two serial data lines:
// reset pulse, CONVST pulse, BUSY handshake with timeout, 64-bit read, sample output.
module adc_controller #(
    parameter int W_CHAN    = 5,
    parameter int W_DATA    = 18,
    parameter int W_ADC     = 16,
    parameter int N_CHAN    = 8,
    parameter int CLK_DIV   = 2,
    parameter int T_RESET   = 8,
    parameter int T_CONVST  = 4,
    parameter int T_BUSY_TO = 1024
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cstart_in,
    input  logic [2:0]        os_in,
    input  logic              adc_busy_in,
    input  logic              adc_data_a_in,
    input  logic              adc_data_b_in,
    output logic [2:0]        adc_os_out,
    output logic              adc_convst_out,
    output logic              adc_cs_out,
    output logic              adc_sclk_out,
    output logic              adc_reset_out,
    output logic              dv_out,
    output logic [W_CHAN-1:0] chan_out,
    output logic [W_DATA-1:0] data_out,
    output logic              timeout_out
);

    localparam int SH_W    = 64;
    localparam int SPL     = N_CHAN / 2;
    localparam int CW      = $clog2(N_CHAN);
    localparam int CNT_MAX = (T_BUSY_TO > T_RESET) ?
                             ((T_BUSY_TO > T_CONVST) ? T_BUSY_TO : T_CONVST) :
                             ((T_RESET > T_CONVST) ? T_RESET : T_CONVST);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(SH_W + 1);

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_CONVST  = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;

    logic [2:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [BIT_W-1:0]  bits_q,   bits_d;
    logic [SH_W-1:0]   sh_a_q,   sh_a_d;
    logic [SH_W-1:0]   sh_b_q,   sh_b_d;
    logic [2:0]        os_q,     os_d;
    logic              convst_q, convst_d;
    logic              cs_q,     cs_d;
    logic              sclk_q,   sclk_d;
    logic              rsto_q,   rsto_d;
    logic              dv_q,     dv_d;
    logic [W_CHAN-1:0] chan_q,   chan_d;
    logic [W_DATA-1:0] data_q,   data_d;
    logic              to_q,     to_d;

    logic              start;
    logic [CW-1:0]     chan_nxt;
    logic [W_ADC-1:0]  samp [N_CHAN];

    function automatic logic [W_DATA-1:0] sext(input logic [W_ADC-1:0] s);
        return {{(W_DATA-W_ADC){s[W_ADC-1]}}, s};
    endfunction

    // Each line carries its channels back to back, lowest channel in the MSBs.
    always_comb begin
        for (int k = 0; k < SPL; k++) begin
            samp[k]       = sh_a_q[SH_W-1-k*W_ADC -: W_ADC];
            samp[k + SPL] = sh_b_q[SH_W-1-k*W_ADC -: W_ADC];
        end
    end

    assign chan_nxt = chan_q[CW-1:0] + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bits_d   = bits_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        os_d     = os_q;
        convst_d = convst_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        rsto_d   = rsto_q;
        dv_d     = 1'b0;
        chan_d   = chan_q;
        data_d   = data_q;
        to_d     = to_q;
        start    = 1'b0;

        case (state_q)
            S_RESET: begin
                if (cnt_q == CNT_W'(T_RESET - 1)) begin
                    rsto_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (cstart_in) start = 1'b1;
            end
            S_CONVST: begin
                if (cnt_q == CNT_W'(T_CONVST - 1)) begin
                    convst_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_WAIT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (adc_busy_in) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (cnt_q == CNT_W'(T_BUSY_TO - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!adc_busy_in) begin
                    cnt_d   = '0;
                    div_d   = '0;
                    bits_d  = '0;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    state_d = S_READ;
                end else if (cnt_q == CNT_W'(T_BUSY_TO - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sh_a_d = {sh_a_q[SH_W-2:0], adc_data_a_in};
                        sh_b_d = {sh_b_q[SH_W-2:0], adc_data_b_in};
                        bits_d = bits_q + 1'b1;
                    end else if (bits_q == BIT_W'(SH_W)) begin
                        // Last high phase done: release CS and present channel 0 at once.
                        cs_d    = 1'b1;
                        dv_d    = 1'b1;
                        chan_d  = '0;
                        data_d  = sext(samp[0]);
                        state_d = S_OUT;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_OUT: begin
                if (chan_q == W_CHAN'(N_CHAN - 1)) begin
                    if (cstart_in) start = 1'b1;
                    else           state_d = S_IDLE;
                end else begin
                    dv_d   = 1'b1;
                    chan_d = chan_q + 1'b1;
                    data_d = sext(samp[chan_nxt]);
                end
            end
            default: begin
                rsto_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_RESET;
            end
        endcase

        if (start) begin
            os_d     = os_in;
            convst_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_CONVST;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            div_q    <= '0;
            bits_q   <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            os_q     <= '0;
            convst_q <= 1'b1;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            rsto_q   <= 1'b1;
            dv_q     <= 1'b0;
            chan_q   <= '0;
            data_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            os_q     <= os_d;
            convst_q <= convst_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            rsto_q   <= rsto_d;
            dv_q     <= dv_d;
            chan_q   <= chan_d;
            data_q   <= data_d;
            to_q     <= to_d;
        end
    end

    assign adc_os_out     = os_q;
    assign adc_convst_out = convst_q;
    assign adc_cs_out     = cs_q;
    assign adc_sclk_out   = sclk_q;
    assign adc_reset_out  = rsto_q;
    assign dv_out         = dv_q;
    assign chan_out       = chan_q;
    assign data_out       = data_q;
    assign timeout_out    = to_q;

endmodule

// File: tb/tb_adc_controller.sv
// Bench for adc_controller: behavioural ADC (BUSY + two serial lines), table vectors,
// random conversions scored against a sign-extension model, and multi-cycle corner sequences.
module tb_adc_controller;

    logic        clk_in = 1'b0;
    logic        rst_in, cstart_in, adc_busy_in;
    logic [2:0]  os_in;
    logic        adc_data_a_in, adc_data_b_in;
    logic [2:0]  adc_os_out;
    logic        adc_convst_out, adc_cs_out, adc_sclk_out, adc_reset_out;
    logic        dv_out, timeout_out;
    logic [4:0]  chan_out;
    logic [17:0] data_out;

    adc_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .cstart_in(cstart_in), .os_in(os_in),
        .adc_busy_in(adc_busy_in), .adc_data_a_in(adc_data_a_in), .adc_data_b_in(adc_data_b_in),
        .adc_os_out(adc_os_out), .adc_convst_out(adc_convst_out), .adc_cs_out(adc_cs_out),
        .adc_sclk_out(adc_sclk_out), .adc_reset_out(adc_reset_out), .dv_out(dv_out),
        .chan_out(chan_out), .data_out(data_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]        os;
        logic [15:0]       busy_len;
        logic [7:0][15:0]  s;
        logic [7:0][17:0]  e;
    } vec_t;

    vec_t tbl [3];
    int   total = 0, bad = 0;

    // ADC model: BUSY pulse after CONVST, bits presented MSB first, channel 0 first.
    logic [63:0] frame_a = '0, frame_b = '0;
    int          rise_cnt = 0;
    int          busy_len = 200;
    bit          busy_en  = 1'b0;

    assign adc_data_a_in = (rise_cnt < 64) ? frame_a[63 - rise_cnt] : 1'b0;
    assign adc_data_b_in = (rise_cnt < 64) ? frame_b[63 - rise_cnt] : 1'b0;

    always @(negedge adc_cs_out) rise_cnt = 0;
    always @(posedge adc_sclk_out) if (adc_cs_out == 1'b0) rise_cnt = rise_cnt + 1;

    always begin
        @(posedge adc_convst_out);
        if (busy_en) begin
            #1 adc_busy_in = 1'b1;
            repeat (busy_len) @(posedge clk_in);
            #1 adc_busy_in = 1'b0;
        end
    end

    // Monitor
    logic [4:0]  dvc [$];
    logic [17:0] dvd [$];
    int  overlap = 0, follow = 0, cl_run = 0, cl_len = 0, cs_run = 0, cs_len = 0;
    bit  last_dv = 1'b0, mon_en = 1'b0;

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (dv_out) begin dvc.push_back(chan_out); dvd.push_back(data_out); end
            if (!adc_cs_out && !adc_convst_out) overlap++;
            if (!adc_convst_out) cl_run++;
            else if (cl_run != 0) begin cl_len = cl_run; cl_run = 0; end
            if (!adc_cs_out) cs_run++;
            else if (cs_run != 0) begin cs_len = cs_run; cs_run = 0; end
            if (last_dv && !adc_convst_out) follow++;
            last_dv = dv_out && (chan_out == 5'd7);
        end
    end

    function automatic logic [17:0] model(input logic [15:0] s);
        int v = int'(s);
        if (v >= 32768) v = v - 65536;
        return 18'(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic set_frames(input logic [7:0][15:0] s);
        frame_a = {s[0], s[1], s[2], s[3]};
        frame_b = {s[4], s[5], s[6], s[7]};
    endtask

    task automatic do_reset();
        int n = 0;
        @(negedge clk_in) rst_in = 1'b1;
        @(negedge clk_in) rst_in = 1'b0;
        while (adc_reset_out && n < 50) begin @(negedge clk_in); n++; end
    endtask

    task automatic run_conv(input vec_t v, input bit drop_busy, input string nm);
        int n = 0;
        set_frames(v.s);
        busy_len = int'(v.busy_len);
        os_in = v.os;
        dvc.delete(); dvd.delete();
        cstart_in = 1'b1;
        if (drop_busy) while (adc_busy_in !== 1'b1 && n < 600) begin @(negedge clk_in); n++; end
        else           while (adc_convst_out !== 1'b0 && n < 100) begin @(negedge clk_in); n++; end
        cstart_in = 1'b0;
        os_in = ~v.os;
        n = 0;
        while (dvc.size() < 8 && n < 3000) begin @(negedge clk_in); n++; end
        repeat (20) @(negedge clk_in);
        chk({nm, " dv_count"}, dvc.size(), 8);
        chk({nm, " os_out"}, int'(adc_os_out), int'(v.os));
        chk({nm, " convst_len"}, cl_len, 4);
        chk({nm, " cs_len"}, cs_len, 256);
        chk({nm, " idle_convst"}, int'(adc_convst_out), 1);
        for (int k = 0; k < 8; k++) begin
            if (k < dvc.size()) begin
                chk($sformatf("%s chan%0d", nm, k), int'(dvc[k]), k);
                chk($sformatf("%s data%0d", nm, k), int'(dvd[k]), int'(v.e[k]));
            end
        end
    endtask

    initial begin
        vec_t rv;
        int   n;

        rst_in = 1'b1; cstart_in = 1'b0; os_in = 3'd0; adc_busy_in = 1'b0;

        for (int k = 0; k < 8; k++) begin
            tbl[0].s[k] = 16'h1000 + 16'(k);
            tbl[0].e[k] = 18'h01000 + 18'(k);
        end
        tbl[0].s[5] = 16'h8001; tbl[0].e[5] = 18'h38001;
        tbl[0].os = 3'b010; tbl[0].busy_len = 16'd200;
        tbl[1].os = 3'd7;   tbl[1].busy_len = 16'd1;
        tbl[1].s = {16'hABCD, 16'h1234, 16'hFFFE, 16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        tbl[1].e = {18'h3ABCD, 18'h01234, 18'h3FFFE, 18'h00001, 18'h38000, 18'h07FFF, 18'h3FFFF, 18'h00000};
        tbl[2].os = 3'd5;   tbl[2].busy_len = 16'd37;
        tbl[2].s = {16'hF0F0, 16'h0F0F, 16'h7FFF, 16'h8000, 16'hFF00, 16'h00FF, 16'hA5A5, 16'h5A5A};
        tbl[2].e = {18'h3F0F0, 18'h00F0F, 18'h07FFF, 18'h38000, 18'h3FF00, 18'h000FF, 18'h3A5A5, 18'h05A5A};

        // Power-up: one reset cycle, ADC reset held for 8 cycles
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst dv", int'(dv_out), 0);
        chk("rst chan", int'(chan_out), 0);
        chk("rst data", int'(data_out), 0);
        chk("rst convst", int'(adc_convst_out), 1);
        chk("rst cs", int'(adc_cs_out), 1);
        chk("rst sclk", int'(adc_sclk_out), 1);
        chk("rst os", int'(adc_os_out), 0);
        chk("rst timeout", int'(timeout_out), 0);
        n = 0;
        while (adc_reset_out === 1'b1 && n < 50) begin n++; @(negedge clk_in); end
        chk("rst adc_reset_len", n, 8);
        mon_en = 1'b1;
        busy_en = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("idle no convst", int'(adc_convst_out), 1);

        for (int i = 0; i < 3; i++) run_conv(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) begin
                rv.s[k] = 16'($urandom);
                if ($urandom_range(0, 5) == 0) rv.s[k] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                rv.e[k] = model(rv.s[k]);
            end
            rv.os = 3'($urandom_range(0, 7));
            rv.busy_len = 16'($urandom_range(1, 300));
            run_conv(rv, 1'b0, $sformatf("rand%0d", i));
        end

        // Continuous: three back-to-back conversions
        set_frames(tbl[0].s);
        busy_len = 200; os_in = 3'b010;
        dvc.delete(); dvd.delete(); follow = 0;
        cstart_in = 1'b1;
        n = 0;
        while (dvc.size() < 24 && n < 6000) begin
            @(negedge clk_in); n++;
            if (dvc.size() >= 16 && !adc_convst_out) cstart_in = 1'b0;
        end
        cstart_in = 1'b0;
        repeat (20) @(negedge clk_in);
        chk("cont dv_count", dvc.size(), 24);
        chk("cont follow", follow, 2);
        for (int i = 0; i < 24; i++)
            if (i < dvc.size()) chk($sformatf("cont data%0d", i), int'(dvd[i]), int'(tbl[0].e[i % 8]));

        // cstart dropped while BUSY is high
        run_conv(tbl[1], 1'b1, "drop_wait_lo");

        // Timeout: BUSY never rises
        busy_en = 1'b0;
        dvc.delete(); dvd.delete();
        cstart_in = 1'b1; n = 0;
        while (adc_convst_out !== 1'b0 && n < 100) begin @(negedge clk_in); n++; end
        cstart_in = 1'b0; n = 0;
        while (adc_convst_out === 1'b0 && n < 100) begin @(negedge clk_in); n++; end
        n = 0;
        while (timeout_out !== 1'b1 && n < 2000) begin n++; @(negedge clk_in); end
        chk("to wait_len", n, 1024);
        repeat (100) @(negedge clk_in);
        chk("to sticky", int'(timeout_out), 1);
        chk("to no_dv", dvc.size(), 0);
        chk("to no_read", int'(adc_cs_out), 1);
        do_reset();
        chk("to cleared", int'(timeout_out), 0);
        busy_en = 1'b1;

        // Reset at the 30th sclk rise
        set_frames(tbl[1].s);
        busy_len = 50; os_in = 3'd1;
        dvc.delete(); dvd.delete();
        cstart_in = 1'b1; n = 0;
        while (rise_cnt != 30 && n < 1000) begin @(negedge clk_in); n++; end
        rst_in = 1'b1; cstart_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("midrst cs", int'(adc_cs_out), 1);
        chk("midrst sclk", int'(adc_sclk_out), 1);
        chk("midrst adc_reset", int'(adc_reset_out), 1);
        repeat (40) @(negedge clk_in);
        chk("midrst no_dv", dvc.size(), 0);
        run_conv(tbl[2], 1'b0, "after_midrst");

        chk("cs_convst_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_controller.md
ADC_CONTROLLER -- requirements
Module: adc_controller

Interface
REQ-001 Parameter W_CHAN, 5, width of chan_out.
REQ-002 Parameter W_DATA, 18, width of data_out; ADC samples are sign-extended to it.
REQ-003 Parameter W_ADC, 16, ADC sample width.
REQ-004 Parameter N_CHAN, 8, ADC channels per conversion; DOUTA carries channels 0-3 and DOUTB carries channels 4-7.
REQ-005 Parameter CLK_DIV, 2, clk cycles per sclk half-period.
REQ-006 Parameter T_RESET, 8, clk cycles adc_reset_out is held high.
REQ-007 Parameter T_CONVST, 4, clk cycles adc_convst_out is held low.
REQ-008 Parameter T_BUSY_TO, 1024, clk cycles to wait for each busy edge before timeout.
REQ-009 The block SHALL have one clock, clk_in; rst_in is a synchronous, active-high reset.
REQ-010 The ports SHALL be, in order (name, direction, width, meaning):
- clk_in, in, 1, system clock.
- rst_in, in, 1, synchronous active-high reset.
- cstart_in, in, 1, level; conversions repeat while high.
- os_in, in, 3, ADC oversample code.
- adc_busy_in, in, 1, ADC BUSY.
- adc_data_a_in, in, 1, ADC DOUTA.
- adc_data_b_in, in, 1, ADC DOUTB.
- adc_os_out, out, 3, ADC OS pins.
- adc_convst_out, out, 1, CONVST, active-low pulse.
- adc_cs_out, out, 1, chip select, active low.
- adc_sclk_out, out, 1, serial clock, idles high.
- adc_reset_out, out, 1, ADC RESET, active high.
- dv_out, out, 1, sample valid.
- chan_out, out, W_CHAN, sample channel.
- data_out, out, W_DATA, signed sample.
- timeout_out, out, 1, sticky busy-timeout flag.

Function
REQ-011 The FSM SHALL have the states RESET, IDLE, CONVST, WAIT_HI, WAIT_LO, READ and OUT.
REQ-012 RESET SHALL hold adc_reset_out=1 for T_RESET cycles and then go to IDLE.
REQ-013 IDLE: when cstart_in=1, the block SHALL latch os_in into adc_os_out and go to CONVST on the next edge.
REQ-014 CONVST SHALL drive adc_convst_out=0 for exactly T_CONVST cycles, then return it to 1 and go to WAIT_HI.
REQ-015 WAIT_HI SHALL go to WAIT_LO when adc_busy_in=1.
REQ-016 WAIT_LO SHALL go to READ when adc_busy_in=0.
REQ-017 A counter SHALL bound each of WAIT_HI and WAIT_LO to T_BUSY_TO cycles; on expiry the block SHALL set timeout_out=1 and go to IDLE with no output.
REQ-018 READ SHALL drive adc_cs_out=0 and generate 64 sclk periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-019 During READ, both data lines SHALL be sampled on the clk edge where sclk rises, MSB first.
REQ-020 During READ, the shift registers SHALL be 64 bits per line, giving 4 samples of W_ADC bits per line.
REQ-021 After the 64th rising sclk edge, the block SHALL set adc_cs_out=1, keep sclk high, and go to OUT.
REQ-022 OUT SHALL assert dv_out for N_CHAN consecutive cycles, with chan_out=0..N_CHAN-1 ascending.
REQ-023 In OUT, data_out SHALL be the two's-complement sign extension of the channel's W_ADC sample.
REQ-024 After the last OUT cycle, the block SHALL go to CONVST if cstart_in=1 (relatching os_in), else to IDLE.
REQ-025 Outside OUT, dv_out SHALL be 0; chan_out and data_out SHALL hold their last values.
REQ-026 Deasserting cstart_in mid-cycle SHALL let the current conversion complete through OUT.
REQ-027 os_in changes SHALL take effect only at the next conversion start.
REQ-028 timeout_out SHALL clear only on rst_in.
REQ-029 adc_cs_out and adc_convst_out SHALL never be low in the same cycle.

Reset
REQ-030 On rst_in=1 at any clk edge, the block SHALL enter RESET and set dv_out=0, chan_out=0, data_out=0, adc_convst_out=1, adc_cs_out=1, adc_sclk_out=1, adc_os_out=0, timeout_out=0 and all counters to 0.
REQ-031 On rst_in=1, adc_reset_out SHALL be 1 from the next edge.
REQ-032 A reset during READ or OUT SHALL discard partial data, and no further dv_out SHALL be asserted.

Verification
REQ-033 Power-up: rst_in high 1 cycle -> adc_reset_out high 8 cycles, all other outputs at their reset values, FSM in IDLE.
REQ-034 Single conversion: cstart_in=1, os_in=3'b010, ADC model with busy high 200 cycles, channel k=0x1000+k, channel 5=0x8001 -> adc_os_out=2, convst low 4 cycles, 256-cycle read, dv_out for 8 cycles, chan 0..7, data 0x01000..0x01007 except chan 5 = 0x38001.
REQ-035 Continuous: cstart_in held high 3 conversions -> 24 dv pulses; CONVST follows each OUT immediately; cs never low during convst.
REQ-036 Timeout: busy held low forever -> timeout_out=1 after 1024 WAIT_HI cycles, FSM in IDLE, no dv_out; timeout_out stays 1 until rst_in.
REQ-037 Mid-read reset: rst_in at the 30th sclk rise -> adc_cs_out=1 next cycle, no dv_out, and the next conversion reads correct data.
REQ-038 cstart_in dropped during WAIT_LO -> conversion completes with 8 samples, then FSM in IDLE.
